stick_game_display: RTL and testbench

Downstream consumer of the falling-stick map generator's 64-bit frame. Latches each new frame on the map clock's rising edge and tracks the player's column on the bottom row from left/right button pulses. Detects collision with a stick and counts sticks survived. Time-multiplexes the composite image onto an 8×8 LED dot matrix through active-low row strobes and active-high column data.

---
 rtl/stick_game_display_pkg.sv | 21 ++
 rtl/stick_game_display_matrix_row_scanner.sv | 53 +++++
 rtl/stick_game_display.sv | 103 ++++++++++
 tb/tb_stick_game_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stick_game_display_pkg.sv
// Shared geometry constants, game state type and frame row-slice helper
// for the stick game display.
package stick_game_display_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int FB_W = 64;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } game_state_e;

    // Row r of a frame occupies bits [8r+7:8r].
    function automatic logic [COLS-1:0] row_slice(input logic [FB_W-1:0] frame,
                                                  input logic [2:0]      idx);
        return frame[{idx, 3'b000} +: COLS];
    endfunction

endpackage

// File: rtl/stick_game_display_matrix_row_scanner.sv
// Time-multiplexes a 64-bit composite image onto an 8x8 matrix:
// each row is strobed (active low) for SCAN_DIV cycles.
module matrix_row_scanner
    import stick_game_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [FB_W-1:0] image_i,
    output logic [ROWS-1:0] row_n_o,
    output logic [COLS-1:0] col_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       row_idx_q, row_idx_d;
    logic [ROWS-1:0]  row_n_q;
    logic [COLS-1:0]  col_q;

    // Row dwell counter; the row index advances when the counter wraps.
    always_comb begin
        div_cnt_d = div_cnt_q;
        row_idx_d = row_idx_q;
        if (div_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            div_cnt_d = {CNT_W{1'b0}};
            row_idx_d = row_idx_q + 3'd1;
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
            row_idx_d = row_idx_q;
        end
    end

    // Scan state and registered matrix drive, one cycle behind row_idx.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= {CNT_W{1'b0}};
            row_idx_q <= 3'd0;
            row_n_q   <= 8'hFF;
            col_q     <= 8'h00;
        end else begin
            div_cnt_q <= div_cnt_d;
            row_idx_q <= row_idx_d;
            row_n_q   <= ~(8'b0000_0001 << row_idx_q);
            col_q     <= row_slice(image_i, row_idx_q);
        end
    end

    assign row_n_o = row_n_q;
    assign col_o   = col_q;

endmodule

// File: rtl/stick_game_display.sv
// Falling-stick game front end: latches map frames, moves the player on the
// bottom row, detects collisions, keeps score and drives the LED matrix.
module stick_game_display
    import stick_game_display_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int PLAYER_START = 3
) (
    input  logic            system_clk,
    input  logic            rst,
    input  logic [FB_W-1:0] framebuffer,
    input  logic            map_generate_clk,
    input  logic            btn_left,
    input  logic            btn_right,
    output logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col,
    output logic [2:0]      player_col,
    output logic            game_over,
    output logic [7:0]      score
);

    logic            mg_q;
    logic [FB_W-1:0] snap_q, snap_d;
    logic [2:0]      player_q, player_d;
    logic [7:0]      score_q, score_d;
    game_state_e     state_q, state_d;
    logic            tick_s;
    logic            hit_s;
    logic [FB_W-1:0] image_s;

    assign tick_s = map_generate_clk & ~mg_q;
    assign hit_s  = snap_q[{3'b111, player_q}];

    // Next-state for frame, player, score and game state; all frozen once over.
    always_comb begin
        snap_d   = snap_q;
        player_d = player_q;
        score_d  = score_q;
        state_d  = state_q;
        case (state_q)
            ST_PLAY: begin
                if (tick_s) begin
                    snap_d = framebuffer;
                end else begin
                    snap_d = snap_q;
                end
                case ({btn_left, btn_right})
                    2'b10:   player_d = (player_q == 3'd0) ? 3'd0 : player_q - 3'd1;
                    2'b01:   player_d = (player_q == 3'd7) ? 3'd7 : player_q + 3'd1;
                    default: player_d = player_q;
                endcase
                // The retiring bottom row counts only if it held a stick and missed us.
                if (tick_s && (row_slice(snap_q, 3'd7) != 8'h00) && !hit_s
                    && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 8'd1;
                end else begin
                    score_d = score_q;
                end
                if (hit_s) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_PLAY;
        endcase
    end

    // Game state registers.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            mg_q     <= 1'b0;
            snap_q   <= {FB_W{1'b0}};
            player_q <= 3'(PLAYER_START);
            score_q  <= 8'd0;
            state_q  <= ST_PLAY;
        end else begin
            mg_q     <= map_generate_clk;
            snap_q   <= snap_d;
            player_q <= player_d;
            score_q  <= score_d;
            state_q  <= state_d;
        end
    end

    assign image_s = snap_q | ({{(FB_W-1){1'b0}}, 1'b1} << {3'b111, player_q});

    matrix_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk_i   (system_clk),
        .rst_i   (rst),
        .image_i (image_s),
        .row_n_o (row_n),
        .col_o   (col)
    );

    assign player_col = player_q;
    assign game_over  = (state_q == ST_OVER);
    assign score      = score_q;

endmodule

// File: tb/tb_stick_game_display.sv
// Directed plus randomized bench for stick_game_display against a cycle-level
// behavioural model of the game and scan rules.
module tb_stick_game_display;

    localparam int SD = 4;
    localparam int PS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] framebuffer = 64'd0;
    logic        mg = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [7:0]  row_n;
    logic [7:0]  col;
    logic [2:0]  player_col;
    logic        game_over;
    logic [7:0]  score;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [63:0] m_snap;
    int          m_player;
    bit          m_over;
    int          m_score;
    bit          m_mg;
    int          m_t;
    logic [7:0]  m_row_n;
    logic [7:0]  m_col;

    stick_game_display #(.SCAN_DIV(SD), .PLAYER_START(PS)) dut (
        .system_clk       (clk),
        .rst              (rst),
        .framebuffer      (framebuffer),
        .map_generate_clk (mg),
        .btn_left         (btn_left),
        .btn_right        (btn_right),
        .row_n            (row_n),
        .col              (col),
        .player_col       (player_col),
        .game_over        (game_over),
        .score            (score)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the game rules for one clock edge, using inputs as seen at that edge.
    task automatic model_edge();
        int          row;
        int          np;
        bit          tick;
        bit          hit;
        logic [63:0] img;
        if (rst) begin
            m_snap = 64'd0; m_player = PS; m_over = 1'b0; m_score = 0;
            m_mg = 1'b0; m_t = 0; m_row_n = 8'hFF; m_col = 8'h00;
        end else begin
            row = (m_t / SD) % 8;
            img = m_snap | (64'd1 << (56 + m_player));
            m_row_n = ~(8'd1 << row);
            m_col = img[row*8 +: 8];
            m_t++;
            tick = mg && !m_mg;
            hit = m_snap[56 + m_player];
            if (!m_over) begin
                np = m_player;
                if (btn_left && !btn_right) np = (m_player == 0) ? 0 : m_player - 1;
                if (btn_right && !btn_left) np = (m_player == 7) ? 7 : m_player + 1;
                if (tick && m_snap[63:56] != 8'd0 && !hit && m_score < 255) m_score++;
                if (tick) m_snap = framebuffer;
                if (hit) m_over = 1'b1;
                m_player = np;
            end
            m_mg = mg;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("row_n", row_n, m_row_n);
        check("col", col, m_col);
        check("player_col", player_col, m_player[2:0]);
        check("game_over", game_over, m_over);
        check("score", score, m_score[7:0]);
    endtask

    task automatic tick_frame(input logic [63:0] fb);
        framebuffer = fb; mg = 1'b1; step();
        mg = 1'b0; step();
    endtask

    task automatic pulse(input bit l, input bit r);
        btn_left = l; btn_right = r; step();
        btn_left = 1'b0; btn_right = 1'b0; step();
    endtask

    task automatic wait_row(input int r, input logic [7:0] exp_col);
        logic [7:0] tgt;
        bit found;
        tgt = ~(8'd1 << r);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (row_n === tgt) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_strobe_seen", found, 1'b1);
        check("scan_row_col", col, exp_col);
    endtask

    initial begin
        int mg_cnt;
        logic [63:0] rnd;

        // Reset
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_row_n", row_n, 8'hFF);
        check("rst_col", col, 8'h00);
        check("rst_player", player_col, 3'd3);
        check("rst_score", score, 8'd0);
        check("rst_over", game_over, 1'b0);
        rst = 1'b0;
        step();
        check("first_strobe", row_n, 8'hFE);

        // Scan order on a diagonal frame
        tick_frame(64'h8040201008040201);
        for (int r = 1; r < 8; r++) wait_row(r, (r == 7) ? 8'h88 : (8'd1 << r));
        wait_row(0, 8'h01);

        // Left saturation and simultaneous buttons
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0);
            if (i == 2) check("left_3_pulses", player_col, 3'd0);
        end
        check("left_saturated", player_col, 3'd0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check("both_buttons", player_col, 3'd1);

        // Survival and scoring from a fresh game
        rst = 1'b1; step(); rst = 1'b0; step();
        tick_frame(64'hF7 << 56);
        step(); step();
        check("survive_no_over", game_over, 1'b0);
        check("survive_score0", score, 8'd0);
        tick_frame(64'hF7 << 56);
        check("survive_score1", score, 8'd1);
        for (int i = 0; i < 5; i++) tick_frame(64'hF7 << 56);
        check("survive_score6", score, 8'd6);

        // Collision
        framebuffer = 64'hFE << 56; mg = 1'b1; step();
        mg = 1'b0;
        check("coll_not_yet", game_over, 1'b0);
        step();
        check("coll_over", game_over, 1'b1);
        check("coll_score", score, 8'd7);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick_frame(64'h0);
        tick_frame(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3 * SD * 8; i++) step();
        check("over_player_frozen", player_col, 3'd3);
        check("over_score_frozen", score, 8'd7);
        check("over_sticky", game_over, 1'b1);

        // Reset mid-game
        rst = 1'b1; step();
        check("mid_rst_row_n", row_n, 8'hFF);
        check("mid_rst_col", col, 8'h00);
        check("mid_rst_player", player_col, 3'd3);
        check("mid_rst_score", score, 8'd0);
        check("mid_rst_over", game_over, 1'b0);
        rst = 1'b0;

        // Randomized play
        mg_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0) || (m_over && $urandom_range(0, 29) == 0);
            btn_left  = ($urandom_range(0, 4) == 0);
            btn_right = ($urandom_range(0, 4) == 0);
            if (mg_cnt == 0) begin
                mg = ~mg;
                mg_cnt = $urandom_range(1, 6);
                if (mg) begin
                    rnd = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    framebuffer = rnd;
                end
            end else begin
                mg_cnt--;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
